// File: rtl/shift_normalizer.sv
// Serial leading-zero counter that drives an external barrel shifter and returns
// the normalised word plus its leading-zero count over a valid/ready handshake.
module shift_normalizer #(
  parameter int N = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2**N-1:0]    in_data,
  output logic [2**N-1:0]    sh_A,
  output logic [N-1:0]       sh_shamt,
  input  logic [2**N-1:0]    sh_Y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2**N-1:0]    out_data,
  output logic [N:0]         out_lzc,
  output logic               out_zero
);

  localparam int W = 2**N;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   state;
  logic [W-1:0] word;
  logic [N-1:0] cnt;
  logic [N-1:0] bit_idx;

  // Examined bit position is W-1-cnt, which for a power-of-two width is ~cnt.
  assign bit_idx   = ~cnt;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // sh_A/sh_shamt are loaded on the SCAN->SHIFT transition so the shifter
  // inputs are already settled for the whole SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word     <= '0;
      cnt      <= '0;
      sh_A     <= '0;
      sh_shamt <= '0;
      out_data <= '0;
      out_lzc  <= '0;
      out_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word  <= in_data;
            cnt   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (word[bit_idx]) begin
            sh_A     <= word;
            sh_shamt <= cnt;
            state    <= SHIFT;
          end else if (cnt == N'(W - 1)) begin
            out_lzc  <= (N+1)'(W);
            out_zero <= 1'b1;
            out_data <= '0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          out_data <= sh_Y;
          out_lzc  <= {1'b0, cnt};
          out_zero <= 1'b0;
          state    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer with a combinational left shifter on the
// sh_* ports; directed cases first, then random words with random back-pressure.
module tb_shift_normalizer;

  localparam int N = 2;
  localparam int W = 2**N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] sh_A;
  logic [N-1:0] sh_shamt;
  logic [W-1:0] sh_Y;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic [N:0]   out_lzc;
  logic         out_zero;

  typedef struct {
    logic [W-1:0] data;
    int           lzc;
    logic         zero;
    int           lat;
    int           accept;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cycle = 0;
  logic random_mode = 1'b0;
  logic hold_low = 1'b0;
  logic pending_idle = 1'b0;
  logic prev_valid = 1'b0;

  shift_normalizer #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sh_A(sh_A), .sh_shamt(sh_shamt), .sh_Y(sh_Y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lzc(out_lzc), .out_zero(out_zero)
  );

  // Stands in for the attached shifter #(N): Y = A << shamt.
  assign sh_Y = sh_A << sh_shamt;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input int got, input int exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic void model(input logic [W-1:0] d, output logic [W-1:0] od,
                                output int lzc);
    lzc = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (d[i]) begin
        lzc = W - 1 - i;
        break;
      end
    end
    od = (lzc == W) ? '0 : W'(d << lzc);
  endfunction

  task automatic applyStimulus(input logic [W-1:0] d, input bit push);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", int'(in_ready), 1);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) begin
      model(d, e.data, e.lzc);
      e.zero   = (e.lzc == W);
      e.lat    = e.zero ? W : e.lzc + 2;
      e.accept = cycle;
      sb.push_back(e);
    end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 0);
  endtask

  // Back-pressure driver; changes just after the edge so the DUT sees a stable value.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold_low) out_ready = 1'b0;
      else if (random_mode) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
    end
  end

  // Output monitor: latency on the rising edge of out_valid, result and stability
  // while valid, in_ready behaviour around the handshake, and the MSB invariant.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid   = 1'b0;
        pending_idle = 1'b0;
      end else begin
        if (pending_idle) begin
          checkOutput("in_ready_after_hs", int'(in_ready), 1);
          pending_idle = 1'b0;
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_valid", sb.size(), 1);
          end else begin
            if (!prev_valid) checkOutput("latency", cycle - sb[0].accept, sb[0].lat);
            checkOutput("out_data", int'(out_data), int'(sb[0].data));
            checkOutput("out_lzc", int'(out_lzc), sb[0].lzc);
            checkOutput("out_zero", int'(out_zero), int'(sb[0].zero));
            checkOutput("in_ready_busy", int'(in_ready), 0);
            if (!out_zero) begin
              checkOutput("inv_msb", int'(out_data[W-1]), 1);
              checkOutput("inv_lzc", int'(out_lzc < (N+1)'(W)), 1);
            end
            if (out_ready) begin
              void'(sb.pop_front());
              pending_idle = 1'b1;
            end
          end
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_out_lzc", int'(out_lzc), 0);
    checkOutput("rst_out_zero", int'(out_zero), 0);
    checkOutput("rst_sh_A", int'(sh_A), 0);
    checkOutput("rst_sh_shamt", int'(sh_shamt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] directed words");
    applyStimulus(4'b0011, 1'b1);
    waitDrain(50);
    applyStimulus(4'b1000, 1'b1);
    waitDrain(50);
    applyStimulus(4'b0000, 1'b1);
    waitDrain(50);
    applyStimulus(4'b0100, 1'b1);
    applyStimulus(4'b0110, 1'b1);
    waitDrain(50);

    $display("[TB] held result under back-pressure");
    hold_low = 1'b1;
    applyStimulus(4'b0001, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("hold_valid_seen", int'(out_valid), 1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("hold_valid", int'(out_valid), 1);
      checkOutput("hold_data", int'(out_data), 8);
      checkOutput("hold_lzc", int'(out_lzc), 3);
      checkOutput("hold_in_ready", int'(in_ready), 0);
    end
    hold_low = 1'b0;
    waitDrain(50);

    $display("[TB] reset during scan");
    applyStimulus(4'b0001, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_out_valid", int'(out_valid), 0);
    checkOutput("abort_in_ready", int'(in_ready), 1);
    repeat (8) @(negedge clk);
    checkOutput("abort_discarded", int'(out_valid), 0);

    $display("[TB] random words");
    random_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(W'($urandom_range(0, W * W - 1)), 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    random_mode = 1'b0;
    waitDrain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
